jtag_debug_cmd_sysclk: RTL and testbench

//  System-clock side of the debug JTAG path, N-channel parametrised successor of the fixed 2-bit-IR sysclk decoder.

---
 rtl/jtag_dbg_pkg.sv | 15 +
 rtl/dbg_sync_edge.sv | 30 +++
 rtl/jtag_debug_cmd_sysclk.sv | 187 ++++++++++++++++++
 tb/tb_jtag_debug_cmd_sysclk.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dbg_pkg.sv
// Shared types and helpers for the system-clock side of the debug JTAG path.
package jtag_dbg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } dbg_state_e;

  localparam int DEF_ACT_BIT = 34;

  function automatic int nCh(input int irW);
    return 1 << irW;
  endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-stage synchroniser for a tck-domain level plus a registered rising-edge detector.
module dbg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  // Shift the async level through the chain and register a one-cycle rise pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/jtag_debug_cmd_sysclk.sv
// System-clock debug command decoder: synchronises update strobes, captures the
// shifted command and holds it under a valid/ready handshake until accepted.
// Optional pending-command timeout is enabled by defining DBG_CMD_TIMEOUT_EN.
module jtag_debug_cmd_sysclk
  import jtag_dbg_pkg::*;
#(
  parameter  int IR_W        = 2,
  parameter  int SR_W        = 38,
  parameter  int ACT_BIT     = DEF_ACT_BIT,
  parameter  int SYNC_STAGES = 2,
  parameter  int TIMEOUT     = 255,
  localparam int N_CH        = nCh(IR_W)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [IR_W-1:0] i_ir_in,
  input  logic [SR_W-1:0] i_sr,
  input  logic            i_vs_udr,
  input  logic            i_vs_uir,
  input  logic            i_cmd_ready,
  input  logic            i_clr_status,
  output logic [SR_W-1:0] o_jdo,
  output logic            o_cmd_valid,
  output logic [IR_W-1:0] o_cmd_ch,
  output logic            o_cmd_act,
  output logic [N_CH-1:0] o_take_action,
  output logic [N_CH-1:0] o_take_no_action,
  output logic            o_ir_update,
  output logic            o_overrun,
  output logic            o_timeout
);

  localparam logic [N_CH-1:0] ONE_HOT_BASE = N_CH'(1);

  // Parameter sanity checks at elaboration time
  if (SYNC_STAGES < 2 || TIMEOUT < 1 || ACT_BIT >= SR_W) begin : gBadParam
    $error("jtag_debug_cmd_sysclk: illegal parameter combination");
  end

  dbg_state_e      r_state;
  dbg_state_e      w_next_state;
  logic            w_udr_rise;
  logic            w_uir_rise;
  logic            w_capture;
  logic            w_accept;
  logic            w_set_overrun;
  logic            w_expire;
  logic [SR_W-1:0] r_jdo;
  logic [IR_W-1:0] r_cmd_ch;
  logic            r_cmd_act;
  logic [N_CH-1:0] r_take_act;
  logic [N_CH-1:0] r_take_noact;
  logic            r_ir_update;
  logic            r_overrun;

  dbg_sync_edge #(.STAGES(SYNC_STAGES)) uUdrSync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_vs_udr),
    .o_rise  (w_udr_rise)
  );

  dbg_sync_edge #(.STAGES(SYNC_STAGES)) uUirSync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_vs_uir),
    .o_rise  (w_uir_rise)
  );

`ifdef DBG_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_expire = (r_state == PEND) && !i_cmd_ready && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Count pending cycles without acceptance, restarting on every new command
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_cnt <= '0;
    end else if (r_state == PEND && !i_cmd_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
    end else if (i_clr_status) begin
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: capture on an update in IDLE, leave PEND on accept or expiry
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_udr_rise) w_next_state = PEND;
      PEND:    if (i_cmd_ready || w_expire) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: capture, accept and overrun events per state
  always_comb begin
    w_capture     = 1'b0;
    w_accept      = 1'b0;
    w_set_overrun = 1'b0;
    case (r_state)
      IDLE: w_capture = w_udr_rise;
      PEND: begin
        w_accept      = i_cmd_ready;
        w_set_overrun = w_udr_rise;
      end
      default: ;
    endcase
  end

  assign o_cmd_valid = (r_state == PEND);

  // Command capture; jdo keeps its value after the handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_jdo     <= '0;
      r_cmd_ch  <= '0;
      r_cmd_act <= 1'b0;
    end else if (w_capture) begin
      r_jdo     <= i_sr;
      r_cmd_ch  <= i_ir_in;
      r_cmd_act <= i_sr[ACT_BIT];
    end
  end

  // One-hot take pulses and the IR update pulse, each lasting one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_take_act   <= '0;
      r_take_noact <= '0;
      r_ir_update  <= 1'b0;
    end else begin
      r_take_act   <= (w_accept &&  r_cmd_act) ? (ONE_HOT_BASE << r_cmd_ch) : '0;
      r_take_noact <= (w_accept && !r_cmd_act) ? (ONE_HOT_BASE << r_cmd_ch) : '0;
      r_ir_update  <= w_uir_rise;
    end
  end

  // Sticky overrun flag; a new update in the same cycle as a clear keeps it set
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (w_set_overrun) begin
      r_overrun <= 1'b1;
    end else if (i_clr_status) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_jdo            = r_jdo;
  assign o_cmd_ch         = r_cmd_ch;
  assign o_cmd_act        = r_cmd_act;
  assign o_take_action    = r_take_act;
  assign o_take_no_action = r_take_noact;
  assign o_ir_update      = r_ir_update;
  assign o_overrun        = r_overrun;

endmodule

// File: tb/tb_jtag_debug_cmd_sysclk.sv
// Self-checking bench for jtag_debug_cmd_sysclk: directed command table, hand-written
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_jtag_debug_cmd_sysclk;

  localparam int IR_W        = 2;
  localparam int SR_W        = 38;
  localparam int ACT_BIT     = 34;
  localparam int SYNC_STAGES = 2;
  localparam int N_CH        = 1 << IR_W;
  localparam int HIST        = SYNC_STAGES + 3;
`ifdef DBG_CMD_TIMEOUT_EN
  localparam int TB_TIMEOUT  = 8;
  localparam bit TO_EN       = 1'b1;
`else
  localparam int TB_TIMEOUT  = 255;
  localparam bit TO_EN       = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [IR_W-1:0] irIn;
  logic [SR_W-1:0] sr;
  logic            vsUdr;
  logic            vsUir;
  logic            cmdReady;
  logic            clrStatus;
  logic [SR_W-1:0] jdo;
  logic            cmdValid;
  logic [IR_W-1:0] cmdCh;
  logic            cmdAct;
  logic [N_CH-1:0] takeAction;
  logic [N_CH-1:0] takeNoAction;
  logic            irUpdate;
  logic            overrun;
  logic            timeoutFlag;

  int total = 0;
  int bad   = 0;

  // Reference model state: a command is either pending or not
  bit              mPend;
  logic [IR_W-1:0] mCh;
  bit              mAct;
  logic [SR_W-1:0] mJdo;
  bit              mOverrun;
  bit              mTimeout;
  bit              mIrUpd;
  logic [N_CH-1:0] mTakeAct;
  logic [N_CH-1:0] mTakeNoAct;
  int              mPendCnt;
  bit              udrHist[$];
  bit              uirHist[$];

  typedef struct {
    logic [IR_W-1:0] ir;
    bit              act;
    int              readyDelay;
    logic [N_CH-1:0] expAct;
    logic [N_CH-1:0] expNoAct;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  jtag_debug_cmd_sysclk #(
    .IR_W        (IR_W),
    .SR_W        (SR_W),
    .ACT_BIT     (ACT_BIT),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_ir_in          (irIn),
    .i_sr             (sr),
    .i_vs_udr         (vsUdr),
    .i_vs_uir         (vsUir),
    .i_cmd_ready      (cmdReady),
    .i_clr_status     (clrStatus),
    .o_jdo            (jdo),
    .o_cmd_valid      (cmdValid),
    .o_cmd_ch         (cmdCh),
    .o_cmd_act        (cmdAct),
    .o_take_action    (takeAction),
    .o_take_no_action (takeNoAction),
    .o_ir_update      (irUpdate),
    .o_overrun        (overrun),
    .o_timeout        (timeoutFlag)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  // A strobe edge takes effect SYNC_STAGES+1 edges after it is first sampled high.
  task automatic modelUpdate();
    bit udrRise;
    bit uirRise;
    bit setOv;
    bit setTo;
    mTakeAct   = '0;
    mTakeNoAct = '0;
    if (reset) begin
      mPend = 0; mCh = '0; mAct = 0; mJdo = '0;
      mOverrun = 0; mTimeout = 0; mIrUpd = 0; mPendCnt = 0;
      udrHist = {};
      uirHist = {};
      for (int i = 0; i < HIST; i++) begin
        udrHist.push_front(1'b0);
        uirHist.push_front(1'b0);
      end
    end else begin
      udrHist.push_front(vsUdr);
      uirHist.push_front(vsUir);
      void'(udrHist.pop_back());
      void'(uirHist.pop_back());
      udrRise = udrHist[SYNC_STAGES+1] && !udrHist[SYNC_STAGES+2];
      uirRise = uirHist[SYNC_STAGES+1] && !uirHist[SYNC_STAGES+2];
      mIrUpd = uirRise;
      setOv  = 0;
      setTo  = 0;
      if (!mPend) begin
        if (udrRise) begin
          mPend = 1; mJdo = sr; mCh = irIn; mAct = sr[ACT_BIT]; mPendCnt = 0;
        end
      end else begin
        setOv = udrRise;
        if (cmdReady) begin
          if (mAct) mTakeAct[mCh] = 1'b1;
          else      mTakeNoAct[mCh] = 1'b1;
          mPend = 0;
        end else begin
          mPendCnt++;
          if (TO_EN && mPendCnt >= TB_TIMEOUT) begin
            mPend = 0;
            setTo = 1;
          end
        end
      end
      if (setOv) mOverrun = 1; else if (clrStatus) mOverrun = 0;
      if (setTo) mTimeout = 1; else if (clrStatus) mTimeout = 0;
    end
  endtask

  task automatic checkCycle();
    checkOutput("jdo", jdo, mJdo);
    checkOutput("cmd_valid", cmdValid, mPend);
    if (mPend) begin
      checkOutput("cmd_ch", cmdCh, mCh);
      checkOutput("cmd_act", cmdAct, mAct);
    end
    checkOutput("take_action", takeAction, mTakeAct);
    checkOutput("take_no_action", takeNoAction, mTakeNoAct);
    checkOutput("ir_update", irUpdate, mIrUpd);
    checkOutput("overrun", overrun, mOverrun);
    checkOutput("timeout", timeoutFlag, mTimeout);
  endtask

  task automatic stepCycle();
    modelUpdate();
    @(posedge clk);
    #1;
    checkCycle();
  endtask

  task automatic waitValid(input int maxCycles);
    int n = 0;
    while (cmdValid !== 1'b1 && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput("waitValid", cmdValid, 1'b1);
  endtask

  task automatic loadCommand(input logic [IR_W-1:0] ir, input bit act);
    irIn = ir;
    sr = SR_W'({$urandom, $urandom});
    sr[ACT_BIT] = act;
    vsUdr = 1'b1;
    repeat (3) stepCycle();
    vsUdr = 1'b0;
    waitValid(20);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [SR_W-1:0] expJdo;
    loadCommand(v.ir, v.act);
    expJdo = sr;
    repeat (v.readyDelay) stepCycle();
    checkOutput("vecHeldValid", cmdValid, 1'b1);
    cmdReady = 1'b1;
    stepCycle();
    cmdReady = 1'b0;
    checkOutput("vecTakeAction", takeAction, v.expAct);
    checkOutput("vecTakeNoAction", takeNoAction, v.expNoAct);
    checkOutput("vecJdo", jdo, expJdo);
    repeat (HIST + 2) stepCycle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [SR_W-1:0] firstSr;

    vecs[0] = '{ir: 2'd1, act: 1'b1, readyDelay: 0,  expAct: 4'b0010, expNoAct: 4'b0000};
    vecs[1] = '{ir: 2'd3, act: 1'b0, readyDelay: 10, expAct: 4'b0000, expNoAct: 4'b1000};
    vecs[2] = '{ir: 2'd0, act: 1'b1, readyDelay: 3,  expAct: 4'b0001, expNoAct: 4'b0000};
    vecs[3] = '{ir: 2'd2, act: 1'b0, readyDelay: 1,  expAct: 4'b0000, expNoAct: 4'b0100};

    reset = 1'b1; irIn = '0; sr = '0; vsUdr = 1'b0; vsUir = 1'b0;
    cmdReady = 1'b0; clrStatus = 1'b0;
    repeat (3) stepCycle();
    checkOutput("resetValid", cmdValid, 1'b0);
    checkOutput("resetJdo", jdo, '0);
    checkOutput("resetCh", cmdCh, '0);
    checkOutput("resetTake", {takeAction, takeNoAction}, '0);
    checkOutput("resetFlags", {irUpdate, overrun, timeoutFlag}, '0);
    reset = 1'b0;
    repeat (HIST) stepCycle();

    // Directed command table
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Capture latency in edges from first high sample of vs_udr
    $display("[TB] latency sequence");
    irIn = 2'd1; sr = '0; sr[ACT_BIT] = 1'b1;
    vsUdr = 1'b1;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (cmdValid !== 1'b1 && n < 20);
    checkOutput("latencyEdges", n - 1, SYNC_STAGES + 1);
    vsUdr = 1'b0;
    cmdReady = 1'b1; stepCycle(); cmdReady = 1'b0;
    checkOutput("latencyTake", takeAction, 4'b0010);
    repeat (HIST) stepCycle();

    // Second update while pending: overrun, original command retained
    $display("[TB] overrun sequence");
    loadCommand(2'd2, 1'b1);
    firstSr = sr;
    irIn = 2'd0; sr = ~sr;
    vsUdr = 1'b1; repeat (2) stepCycle(); vsUdr = 1'b0;
    repeat (HIST) stepCycle();
    checkOutput("overrunSet", overrun, 1'b1);
    checkOutput("overrunJdo", jdo, firstSr);
    checkOutput("overrunCh", cmdCh, 2'd2);
    clrStatus = 1'b1; stepCycle(); clrStatus = 1'b0;
    checkOutput("overrunClr", overrun, 1'b0);
    cmdReady = 1'b1; stepCycle(); cmdReady = 1'b0;
    checkOutput("overrunTake", takeAction, 4'b0100);
    repeat (HIST) stepCycle();

    // IR update during a pending command
    $display("[TB] ir update sequence");
    loadCommand(2'd1, 1'b0);
    vsUir = 1'b1; repeat (2) stepCycle(); vsUir = 1'b0;
    pulses = (irUpdate === 1'b1) ? 1 : 0;
    for (int i = 0; i < HIST + 2; i++) begin
      stepCycle();
      if (irUpdate === 1'b1) pulses++;
    end
    checkOutput("irUpdatePulses", pulses, 1);
    checkOutput("irUpdateCh", cmdCh, 2'd1);
    cmdReady = 1'b1; stepCycle(); cmdReady = 1'b0;
    checkOutput("irUpdateTake", takeNoAction, 4'b0010);
    repeat (HIST) stepCycle();

    // Reset while pending: command lost without a pulse
    $display("[TB] reset in pending sequence");
    loadCommand(2'd3, 1'b1);
    reset = 1'b1; stepCycle();
    checkOutput("midResetValid", cmdValid, 1'b0);
    checkOutput("midResetJdo", jdo, '0);
    checkOutput("midResetOut", {takeAction, takeNoAction, overrun, timeoutFlag}, '0);
    reset = 1'b0;
    cmdReady = 1'b1; stepCycle(); cmdReady = 1'b0;
    checkOutput("midResetNoPulse", {takeAction, takeNoAction}, '0);
    repeat (HIST) stepCycle();

    // Long wait without cmd_ready
    $display("[TB] timeout sequence");
    loadCommand(2'd0, 1'b0);
`ifdef DBG_CMD_TIMEOUT_EN
    repeat (TB_TIMEOUT - 1) stepCycle();
    checkOutput("toStillValid", cmdValid, 1'b1);
    stepCycle();
    checkOutput("toDropped", cmdValid, 1'b0);
    checkOutput("toFlag", timeoutFlag, 1'b1);
    checkOutput("toNoPulse", {takeAction, takeNoAction}, '0);
    clrStatus = 1'b1; stepCycle(); clrStatus = 1'b0;
    checkOutput("toClr", timeoutFlag, 1'b0);
`else
    repeat (40) stepCycle();
    checkOutput("noToValid", cmdValid, 1'b1);
    checkOutput("noToFlag", timeoutFlag, 1'b0);
    cmdReady = 1'b1; stepCycle(); cmdReady = 1'b0;
    checkOutput("noToTake", takeNoAction, 4'b0001);
`endif
    repeat (HIST) stepCycle();

    // vs_udr already high when reset releases: exactly one command
    $display("[TB] level at reset release sequence");
    reset = 1'b1; vsUdr = 1'b1; irIn = 2'd2; sr = '1;
    repeat (2) stepCycle();
    reset = 1'b0;
    waitValid(20);
    cmdReady = 1'b1; stepCycle(); cmdReady = 1'b0;
    checkOutput("levelTake", takeAction, 4'b0100);
    repeat (HIST + 3) stepCycle();
    checkOutput("levelSingle", cmdValid, 1'b0);
    vsUdr = 1'b0;
    repeat (HIST) stepCycle();

    // Randomized traffic against the model
    $display("[TB] random phase");
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) vsUdr = ~vsUdr;
      if ($urandom_range(0, 7) == 0) vsUir = ~vsUir;
      if ($urandom_range(0, 3) == 0) sr = SR_W'({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) irIn = IR_W'($urandom);
      cmdReady  = ($urandom_range(0, 3) == 0);
      clrStatus = ($urandom_range(0, 15) == 0);
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
